// File: rtl/imem_prefetch_queue.sv
// imem_prefetch_queue: instruction prefetch FIFO with credit-based request
// issue toward a one-cycle-latency instruction memory.
//
// Ports:
//   clk, reset (sync, active-low)   - clock and reset
//   start, redirect, redirect_addr  - fetch enable and PC redirect
//   im_req, im_abus, im_dbus        - memory request / address / return word
//   inst_valid, inst_data,
//   inst_addr, inst_ready           - head-entry handshake toward the CPU
//   count                           - occupied queue entries
//
// Optional feature: define IMEM_PFQ_BYPASS_EN to forward a return straight
// to the CPU when the queue is empty (latency 1 instead of 2).

module imem_prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 13,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     redirect,
    input  logic [AW-1:0]            redirect_addr,
    output logic                     im_req,
    output logic [AW-1:0]            im_abus,
    input  logic [DW-1:0]            im_dbus,
    output logic                     inst_valid,
    output logic [DW-1:0]            inst_data,
    output logic [AW-1:0]            inst_addr,
    input  logic                     inst_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] r_pc;
    logic          r_inflight;
    logic [AW-1:0] r_fl_addr;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_mem_data [DEPTH];
    logic [AW-1:0] r_mem_addr [DEPTH];

    logic          w_nonempty;
    logic          w_byp;
    logic          w_pop;
    logic          w_qpop;
    logic          w_push;
    logic [CW:0]   w_used;
    logic          w_credit;

    assign w_nonempty = (r_count != '0);

`ifdef IMEM_PFQ_BYPASS_EN
    // Forward the return of the cycle when nothing older is queued.
    assign w_byp = reset & ~redirect & r_inflight & ~w_nonempty;
`else
    assign w_byp = 1'b0;
`endif

    assign inst_valid = w_nonempty | w_byp;

    always_comb begin
        inst_data = '0;
        inst_addr = '0;
        if (w_nonempty) begin
            inst_data = r_mem_data[r_head];
            inst_addr = r_mem_addr[r_head];
        end else if (w_byp) begin
            inst_data = im_dbus;
            inst_addr = r_fl_addr;
        end
    end

    assign w_pop  = inst_valid & inst_ready;
    assign w_qpop = w_pop & w_nonempty;
    // A bypassed word that the CPU takes is never stored.
    assign w_push = r_inflight & ~(w_byp & inst_ready);

    // Slots already owed: stored entries plus the outstanding return,
    // minus the entry leaving this cycle.
    assign w_used   = {1'b0, r_count} + (CW+1)'(r_inflight)
                    - (CW+1)'(w_pop);
    assign w_credit = (w_used < (CW+1)'(DEPTH));

    assign im_req  = reset & start & ~redirect & w_credit;
    assign im_abus = r_pc;
    assign count   = r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc       <= '0;
            r_inflight <= 1'b0;
            r_fl_addr  <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            // The return arriving now belongs to the old stream: drop it.
            r_pc       <= redirect_addr;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_tail] <= im_dbus;
                r_mem_addr[r_tail] <= r_fl_addr;
                r_tail             <= r_tail + PW'(1);
            end
            if (w_qpop) begin
                r_head <= r_head + PW'(1);
            end
            r_count    <= r_count + CW'(w_push) - CW'(w_qpop);
            r_inflight <= im_req;
            r_fl_addr  <= r_pc;
            if (im_req) begin
                r_pc <= r_pc + AW'(1);
            end
        end
    end

endmodule
